// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment digit scanner: blank gap, then dwell on each digit in turn.
// Optional macro DISPLAY_LEADING_ZERO_BLANK_EN blanks a zero on the most significant digit.
module display_scan_ctrl #(
  parameter int N_DIGITS     = 6,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_en,
  input  logic                  upd_valid,
  input  logic [4*N_DIGITS-1:0] upd_data,
  output logic [3:0]            scan_bcd_out,
  output logic [N_DIGITS-1:0]   scan_digit_out,
  output logic                  scan_frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(N_DIGITS);
  localparam int DW      = 4 * N_DIGITS;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        pending_q, pending_d;
  logic [DW-1:0]        active_q, active_d;
  logic                 wrap_q, wrap_d;
  logic [N_DIGITS-1:0]  digit_q, digit_d;
  logic [3:0]           bcd_q, bcd_d;
  logic                 done_q, done_d;

  logic [3:0]           raw_bcd;
  logic [3:0]           shown_bcd;
  logic [N_DIGITS-1:0]  onehot;

  always_comb begin
    raw_bcd = active_q[idx_q*4 +: 4];
    onehot  = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
  end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  always_comb begin
    shown_bcd = raw_bcd;
    if ((idx_q == IDX_LAST) && (raw_bcd == 4'd0)) begin
      shown_bcd = 4'hF;
    end
  end
`else
  always_comb begin
    shown_bcd = raw_bcd;
  end
`endif

  // Outputs are computed from the current state and registered, so they trail it by one clock.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    active_d  = active_q;
    wrap_d    = 1'b0;
    digit_d   = '0;
    bcd_d     = 4'hF;
    done_d    = 1'b0;

    if (upd_valid) begin
      pending_d = upd_data;
    end

    if (!scan_en) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else begin
      done_d = wrap_q;
      if (state_q == SHOW) begin
        digit_d = onehot;
        bcd_d   = shown_bcd;
      end

      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            // Frame latch reads the pre-update pending value, so a coincident write waits a frame.
            if (idx_q == '0) begin
              active_d = pending_q;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= '1;
      active_q  <= '1;
      wrap_q    <= 1'b0;
      digit_q   <= '0;
      bcd_q     <= 4'hF;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      wrap_q    <= wrap_d;
      digit_q   <= digit_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign scan_bcd_out    = bcd_q;
  assign scan_digit_out  = digit_q;
  assign scan_frame_done = done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed frame tables, corner sequences and a
// randomized run against a slot-position reference model.
module tb_display_scan_ctrl;

  localparam int N = 6;
  localparam int D = 4;
  localparam int B = 2;
  localparam int W = 4 * N;
  localparam int SLOT = B + D;
  localparam int FRAME = SLOT * N;

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ_TOP = 4'hF;
`else
  localparam logic [3:0] LZ_TOP = 4'h0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         scan_en = 1'b0;
  logic         upd_valid = 1'b0;
  logic [W-1:0] upd_data = '0;
  logic [3:0]   scan_bcd_out;
  logic [N-1:0] scan_digit_out;
  logic         scan_frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .N_DIGITS    (N),
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scan_en        (scan_en),
    .upd_valid      (upd_valid),
    .upd_data       (upd_data),
    .scan_bcd_out   (scan_bcd_out),
    .scan_digit_out (scan_digit_out),
    .scan_frame_done(scan_frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit vld, input logic [W-1:0] data);
    scan_en   = en;
    upd_valid = vld;
    upd_data  = data;
  endtask

  // Reference model: position within a digit slot (blank part then dwell part), digit index,
  // and the two digit registers; expected outputs describe the previous position.
  int           m_pos = 0;
  int           m_idx = 0;
  bit           m_wrap = 1'b0;
  logic [W-1:0] m_pend = '1;
  logic [W-1:0] m_act = '1;
  logic [N-1:0] exp_digit = '0;
  logic [3:0]   exp_bcd = 4'hF;
  logic         exp_done = 1'b0;

  function automatic logic [3:0] dispDigit(input logic [W-1:0] v, input int k);
    logic [3:0] d;
    d = v[4*k +: 4];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (k == N - 1 && d == 4'd0) d = 4'hF;
`endif
    return d;
  endfunction

  task automatic modelStep();
    if (!rst_n) begin
      m_pos = 0; m_idx = 0; m_wrap = 1'b0;
      m_pend = '1; m_act = '1;
      exp_digit = '0; exp_bcd = 4'hF; exp_done = 1'b0;
    end else begin
      if (!scan_en) begin
        exp_digit = '0; exp_bcd = 4'hF; exp_done = 1'b0;
        m_pos = 0; m_wrap = 1'b0;
      end else begin
        exp_done = m_wrap;
        m_wrap = 1'b0;
        if (m_pos >= B) begin
          exp_digit = N'(1) << m_idx;
          exp_bcd   = dispDigit(m_act, m_idx);
        end else begin
          exp_digit = '0;
          exp_bcd   = 4'hF;
        end
        if (m_pos == B - 1 && m_idx == 0) m_act = m_pend;
        m_pos++;
        if (m_pos == SLOT) begin
          m_pos  = 0;
          m_idx  = (m_idx + 1) % N;
          m_wrap = (m_idx == 0);
        end
      end
      if (upd_valid) m_pend = upd_data;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    modelStep();
  end

  bit chk_on = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      checkOutput("model_digit", 32'(scan_digit_out), 32'(exp_digit));
      checkOutput("model_bcd", 32'(scan_bcd_out), 32'(exp_bcd));
      checkOutput("model_done", 32'(scan_frame_done), 32'(exp_done));
      checkOutput("onehot", 32'($countones(scan_digit_out) > 1), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitFrameDone(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_frame_done && n < 200);
    if (!scan_frame_done) checkOutput("frame_done_timeout", 32'(scan_frame_done), 1);
  endtask

  task automatic waitDigit(input logic [N-1:0] target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_digit_out != target && n < 200);
    if (scan_digit_out != target) checkOutput("digit_wait_timeout", 32'(scan_digit_out), 32'(target));
  endtask

  // Called at the negedge where frame_done is seen; walks the remaining cycles of that frame.
  task automatic checkFrame(input logic [W-1:0] expv, input string tag);
    for (int q = 1; q < FRAME; q++) begin
      int slot;
      int off;
      @(negedge clk);
      if (q == 1) applyStimulus(scan_en, 1'b0, upd_data);
      slot = q / SLOT;
      off  = q % SLOT;
      if (off < B) begin
        checkOutput({tag, "_gap_digit"}, 32'(scan_digit_out), 0);
        checkOutput({tag, "_gap_bcd"}, 32'(scan_bcd_out), 32'hF);
      end else begin
        checkOutput({tag, "_digit"}, 32'(scan_digit_out), 32'(N'(1) << slot));
        checkOutput({tag, "_bcd"}, 32'(scan_bcd_out), 32'(expv[4*slot +: 4]));
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] expv;
  } vec_t;

  localparam int NV = 4;
  vec_t tbl[NV];

  initial begin
    int  n;
    int  nb;
    bit  seen;

    tbl[0] = '{data: 24'h987654, expv: 24'h987654};
    tbl[1] = '{data: 24'hABCDEF, expv: 24'hABCDEF};
    tbl[2] = '{data: 24'h000000, expv: {LZ_TOP, 20'h00000}};
    tbl[3] = '{data: 24'h091530, expv: {LZ_TOP, 20'h91530}};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    checkOutput("reset_digit", 32'(scan_digit_out), 0);
    checkOutput("reset_bcd", 32'(scan_bcd_out), 32'hF);
    checkOutput("reset_done", 32'(scan_frame_done), 0);

    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, '0);
    nb = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (c == 4) applyStimulus(1'b1, 1'b1, 24'h123456);
      if (c == 5) applyStimulus(1'b1, 1'b0, 24'h123456);
      if (scan_frame_done) seen = 1'b1;
      else if (scan_bcd_out != 4'hF) nb++;
    end
    checkOutput("first_frame_done_seen", 32'(seen), 1);
    checkOutput("first_frame_blank", nb, 0);
    checkFrame(24'h123456, "frame_123456");

    for (int i = 0; i < NV; i++) begin
      waitFrameDone(n);
      repeat (5) @(negedge clk);
      applyStimulus(1'b1, 1'b1, tbl[i].data);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, tbl[i].data);
      waitFrameDone(n);
      checkFrame(tbl[i].expv, "table_frame");
    end

    waitFrameDone(n);
    repeat (2) begin
      waitFrameDone(n);
      checkOutput("frame_period", n, FRAME);
    end

    // Update lands exactly on the frame-latch edge.
    applyStimulus(1'b1, 1'b1, 24'h999999);
    checkFrame(tbl[NV-1].expv, "latch_old");
    waitFrameDone(n);
    checkFrame(24'h999999, "latch_new");

    // Scan disable in the middle of digit 3.
    waitDigit(N'(8));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, upd_data);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("en_low_digit", 32'(scan_digit_out), 0);
      checkOutput("en_low_bcd", 32'(scan_bcd_out), 32'hF);
      checkOutput("en_low_done", 32'(scan_frame_done), 0);
    end
    applyStimulus(1'b1, 1'b0, upd_data);
    repeat (2) begin
      @(negedge clk);
      checkOutput("resume_gap_digit", 32'(scan_digit_out), 0);
    end
    @(negedge clk);
    checkOutput("resume_digit", 32'(scan_digit_out), 32'(N'(8)));
    checkOutput("resume_bcd", 32'(scan_bcd_out), 32'h9);

    // Asynchronous reset while a digit is lit.
    waitDigit(N'(4));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_digit", 32'(scan_digit_out), 0);
    checkOutput("async_rst_bcd", 32'(scan_bcd_out), 32'hF);
    checkOutput("async_rst_done", 32'(scan_frame_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    checkOutput("post_rst_digit", 32'(scan_digit_out), 1);
    checkOutput("post_rst_bcd", 32'(scan_bcd_out), 32'hF);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0), W'($urandom));
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, '0);
    repeat (4) @(negedge clk);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
